// File: rtl/hilo_mdu_if.sv
// Operand/strobe bundle between the control unit and the HI/LO multiply-divide unit.
interface hilo_mdu_if;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output mult, multu, div, divu, mthi, mtlo, flush, a, b,
    input  hi, lo, busy
  );

  modport slave (
    input  mult, multu, div, divu, mthi, mtlo, flush, a, b,
    output hi, lo, busy
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: single-cycle mult/multu/mthi/mtlo and a
// 32-iteration restoring divider with sign fixup, abortable by flush.
module hilo_mdu #(
  parameter int DIV_CYCLES = 32
) (
  input logic       clk,
  input logic       resetn,
  hilo_mdu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        busy_r;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic [4:0]  cnt_r, cnt_nxt_s;
  logic [32:0] rem_r, rem_nxt_s;
  logic [31:0] quot_r, quot_nxt_s;
  logic [31:0] dvsr_r, dvsr_nxt_s;
  logic        neg_q_r, neg_q_nxt_s;
  logic        neg_rem_r, neg_rem_nxt_s;

  logic        b_zero_s;
  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic [32:0] shifted_s;
  logic [32:0] trial_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return 32'd0 - x;
  endfunction

  // |x| as an unsigned magnitude; 0x80000000 maps to itself (2^31)
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

  assign b_zero_s        = (bus.b == 32'd0);
  assign prod_signed_s   = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_unsigned_s = {32'd0, bus.a} * {32'd0, bus.b};
  assign shifted_s       = {rem_r[31:0], quot_r[31]};
  assign trial_s         = shifted_s - {1'b0, dvsr_r};
  assign quot_fix_s      = neg_q_r ? neg32(quot_r) : quot_r;
  assign rem_fix_s       = neg_rem_r ? neg32(rem_r[31:0]) : rem_r[31:0];

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;

  // State register; busy is registered from the next state so it has no input path
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.flush && (bus.div || bus.divu) && !b_zero_s) begin
          state_nxt_s = DIV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = DIV;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: strobe decode in IDLE, one iteration in DIV, writeback in FIX
  always_comb begin
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    cnt_nxt_s     = cnt_r;
    rem_nxt_s     = rem_r;
    quot_nxt_s    = quot_r;
    dvsr_nxt_s    = dvsr_r;
    neg_q_nxt_s   = neg_q_r;
    neg_rem_nxt_s = neg_rem_r;
    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          cnt_nxt_s = 5'd0;
        end else if (bus.div || bus.divu) begin
          if (!b_zero_s) begin
            // div outranks divu when both are strobed
            dvsr_nxt_s    = bus.div ? abs32(bus.b) : bus.b;
            quot_nxt_s    = bus.div ? abs32(bus.a) : bus.a;
            rem_nxt_s     = 33'd0;
            cnt_nxt_s     = 5'd0;
            neg_q_nxt_s   = bus.div & (bus.a[31] ^ bus.b[31]);
            neg_rem_nxt_s = bus.div & bus.a[31];
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end else if (bus.mult) begin
          {hi_nxt_s, lo_nxt_s} = prod_signed_s;
        end else if (bus.multu) begin
          {hi_nxt_s, lo_nxt_s} = prod_unsigned_s;
        end else begin
          if (bus.mthi) begin
            hi_nxt_s = bus.a;
          end else begin
            hi_nxt_s = hi_r;
          end
          if (bus.mtlo) begin
            lo_nxt_s = bus.a;
          end else begin
            lo_nxt_s = lo_r;
          end
        end
      end
      DIV: begin
        if (bus.flush) begin
          cnt_nxt_s = 5'd0;
        end else begin
          if (!trial_s[32]) begin
            rem_nxt_s  = trial_s;
            quot_nxt_s = {quot_r[30:0], 1'b1};
          end else begin
            rem_nxt_s  = shifted_s;
            quot_nxt_s = {quot_r[30:0], 1'b0};
          end
          cnt_nxt_s = (cnt_r == CNT_LAST) ? 5'd0 : cnt_r + 5'd1;
        end
      end
      FIX: begin
        if (bus.flush) begin
          cnt_nxt_s = 5'd0;
        end else begin
          lo_nxt_s = quot_fix_s;
          hi_nxt_s = rem_fix_s;
        end
      end
      default: begin
        cnt_nxt_s = 5'd0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      cnt_r     <= 5'd0;
      rem_r     <= 33'd0;
      quot_r    <= 32'd0;
      dvsr_r    <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rem_r     <= rem_nxt_s;
      quot_r    <= quot_nxt_s;
      dvsr_r    <= dvsr_nxt_s;
      neg_q_r   <= neg_q_nxt_s;
      neg_rem_r <= neg_rem_nxt_s;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: stimulus queues {cycle, hi, lo, busy}
// expectations, a negedge monitor pops and compares them.
module tb_hilo_mdu;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  hilo_mdu_if bus ();

  hilo_mdu #(.DIV_CYCLES(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    string       nm;
  } exp_t;

  exp_t sb[$];

  localparam logic [6:0] S_FLUSH = 7'b1000000;
  localparam logic [6:0] S_DIV   = 7'b0100000;
  localparam logic [6:0] S_DIVU  = 7'b0010000;
  localparam logic [6:0] S_MULT  = 7'b0001000;
  localparam logic [6:0] S_MULTU = 7'b0000100;
  localparam logic [6:0] S_MTHI  = 7'b0000010;
  localparam logic [6:0] S_MTLO  = 7'b0000001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at or before this cycle
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (e.cyc != cyc || bus.hi !== e.hi || bus.lo !== e.lo || bus.busy !== e.busy) begin
        n_err++;
        $display("FAIL %s cyc=%0d (due %0d): hi=%h lo=%h busy=%b, expected hi=%h lo=%h busy=%b",
                 e.nm, cyc, e.cyc, bus.hi, bus.lo, bus.busy, e.hi, e.lo, e.busy);
      end
    end
  end

  task automatic set_strb(input logic [6:0] s, input logic [31:0] a, input logic [31:0] b);
    {bus.flush, bus.div, bus.divu, bus.mult, bus.multu, bus.mthi, bus.mtlo} = s;
    bus.a = a;
    bus.b = b;
  endtask

  // Drive strobes for one edge; on return cyc is the accepting edge
  task automatic issue(input logic [6:0] s, input logic [31:0] a, input logic [31:0] b);
    set_strb(s, a, b);
    @(posedge clk);
    #1;
    set_strb(7'd0, 32'd0, 32'd0);
  endtask

  task automatic expect_at(input string nm, input int dc, input logic [31:0] h,
                           input logic [31:0] l, input logic bz);
    exp_t e;
    e.cyc = cyc + dc; e.hi = h; e.lo = l; e.busy = bz; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Divide: busy from the accepting edge for 33 cycles, result on the 34th
  task automatic expect_div(input string nm, input logic [31:0] h0, input logic [31:0] l0,
                            input logic [31:0] h, input logic [31:0] l);
    expect_at({nm, "_busy0"}, 0, h0, l0, 1'b1);
    expect_at({nm, "_busy32"}, 32, h0, l0, 1'b1);
    expect_at({nm, "_res"}, 33, h, l, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    set_strb(7'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    expect_at("reset", 0, 32'h0, 32'h0, 1'b0);
    drain();

    issue(S_MULT, 32'hFFFFFFFE, 32'd3);
    expect_at("mult", 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    expect_at("mult_hold", 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    drain();

    issue(S_MTHI, 32'h1234, 32'd0);
    expect_at("mthi", 0, 32'h1234, 32'hFFFFFFFA, 1'b0);
    issue(S_MTLO, 32'h5678, 32'd0);
    expect_at("mtlo", 0, 32'h1234, 32'h5678, 1'b0);
    drain();

    issue(S_DIV, 32'd5, 32'd0);
    expect_at("div_b0", 0, 32'h1234, 32'h5678, 1'b0);
    expect_at("div_b0_hold", 1, 32'h1234, 32'h5678, 1'b0);
    drain();

    issue(S_MTHI | S_MTLO, 32'hCAFEF00D, 32'd0);
    expect_at("mthi_mtlo", 0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    drain();

    issue(S_DIV | S_MULT, 32'd3, 32'd0);
    expect_at("div_over_mult", 0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    issue(S_FLUSH | S_MULT, 32'd2, 32'd2);
    expect_at("flush_blocks_mult", 0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    drain();

    issue(S_DIVU, 32'd100, 32'd7);
    expect_div("divu_100_7", 32'hCAFEF00D, 32'hCAFEF00D, 32'd2, 32'd14);
    repeat (4) @(posedge clk);
    #1;
    issue(S_MTHI, 32'hDEADBEEF, 32'd0);
    issue(S_MTLO | S_MULT, 32'hDEADBEEF, 32'd9);
    drain();

    issue(S_DIV, 32'hFFFFFFF9, 32'd2);
    expect_div("div_m7_2", 32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD);
    drain();

    issue(S_DIV, 32'h80000000, 32'hFFFFFFFF);
    expect_div("div_min_m1", 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h80000000);
    drain();

    issue(S_DIV, 32'd7, 32'hFFFFFFFE);
    expect_div("div_7_m2", 32'h0, 32'h80000000, 32'd1, 32'hFFFFFFFD);
    drain();

    issue(S_DIVU, 32'hFFFFFFFF, 32'd10);
    expect_div("divu_max_10", 32'd1, 32'hFFFFFFFD, 32'd5, 32'h19999999);
    drain();

    issue(S_DIVU, 32'd1000, 32'd3);
    expect_at("flush_busy", 0, 32'd5, 32'h19999999, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    issue(S_FLUSH, 32'd0, 32'd0);
    expect_at("flush_abort", 0, 32'd5, 32'h19999999, 1'b0);
    expect_at("flush_no_write", 30, 32'd5, 32'h19999999, 1'b0);
    drain();

    issue(S_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_at("multu_max", 0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    drain();

    issue(S_DIV, 32'hFFFFFF9C, 32'd3);
    expect_at("rst_div_busy", 0, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    repeat (19) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    expect_at("reset_mid_div", 0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    expect_at("reset_release", 0, 32'h0, 32'h0, 1'b0);
    expect_at("reset_no_late_write", 35, 32'h0, 32'h0, 1'b0);
    drain();

    issue(S_MULT, 32'd7, 32'hFFFFFFFA);
    expect_at("mult_after_reset", 0, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
